led_pwm_fader: RTL

- Downstream consumer of the heartbeat LED toggle. Turns the hard on/off level into a smooth fade-in/fade-out of the physical LED using PWM.
- Sits between the heartbeat generator output and the board LED pin.
- Single clock domain; the heartbeat level arrives synchronous to clk.

---
 rtl/led_pwm_fader.sv | 118 +++++++++++
 1 files changed

// File: rtl/led_pwm_fader.sv
// LED fader: turns a heartbeat on/off level into a PWM fade-in/fade-out.
// Optional square-law brightness curve when LED_PWM_FADER_GAMMA_EN is defined.
module led_pwm_fader #(
    parameter int PWM_WIDTH        = 8,
    parameter int RAMP_STEP_CYCLES = 112500,
    parameter int STEP_WIDTH       = 20
) (
    input  logic                 clk,
    input  logic                 s_reset_n,
    input  logic                 led_in,
    input  logic                 enable,
    output logic                 pwm_out,
    output logic [PWM_WIDTH-1:0] level,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    localparam logic [PWM_WIDTH-1:0]  MAX       = '1;
    localparam logic [PWM_WIDTH-1:0]  MAX_M1    = MAX - 1'b1;
    localparam logic [PWM_WIDTH-1:0]  ONE       = PWM_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(RAMP_STEP_CYCLES - 1);

    state_t                 state;
    logic [STEP_WIDTH-1:0]  step_cnt;
    logic [PWM_WIDTH-1:0]   pwm_cnt;
    logic [PWM_WIDTH-1:0]   cmp;
    logic                   led_in_q;
    logic                   enable_q;
    logic                   rise;
    logic                   fall;
    logic                   step_term;

    assign rise      = led_in & ~led_in_q;
    assign fall      = ~led_in & led_in_q;
    assign step_term = (step_cnt == STEP_LAST);
    assign busy      = (state == ST_RISE) || (state == ST_FALL);
    assign state_dbg = state;

`ifdef LED_PWM_FADER_GAMMA_EN
    logic [2*PWM_WIDTH-1:0] level_sq;
    assign level_sq = {{PWM_WIDTH{1'b0}}, level} * {{PWM_WIDTH{1'b0}}, level};
    // Full scale is pinned so the LED is solidly on at the top of the ramp.
    assign cmp = (level == MAX) ? MAX : level_sq[2*PWM_WIDTH-1:PWM_WIDTH];
`else
    assign cmp = level;
`endif

    always_ff @(posedge clk) begin
        if (!s_reset_n) begin
            state    <= ST_OFF;
            level    <= '0;
            step_cnt <= '0;
            pwm_cnt  <= '0;
            led_in_q <= 1'b0;
            enable_q <= 1'b0;
            pwm_out  <= 1'b0;
        end else begin
            led_in_q <= led_in;
            enable_q <= enable;
            pwm_cnt  <= pwm_cnt + 1'b1;
            pwm_out  <= enable & ((cmp == MAX) | (pwm_cnt < cmp));

            if (!enable) begin
                state    <= ST_OFF;
                level    <= '0;
                step_cnt <= '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        step_cnt <= '0;
                        // Re-enabling with the heartbeat already high restarts the fade.
                        if (rise || (!enable_q && led_in_q && led_in)) state <= ST_RISE;
                    end
                    ST_RISE: begin
                        if (fall) begin
                            state    <= ST_FALL;
                            step_cnt <= '0;
                        end else if (step_term) begin
                            step_cnt <= '0;
                            if (level != MAX) level <= level + ONE;
                            if (level == MAX_M1 || level == MAX) state <= ST_ON;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                    ST_ON: begin
                        step_cnt <= '0;
                        if (fall) state <= ST_FALL;
                    end
                    ST_FALL: begin
                        if (rise) begin
                            state    <= ST_RISE;
                            step_cnt <= '0;
                        end else if (step_term) begin
                            step_cnt <= '0;
                            if (level != '0) level <= level - ONE;
                            if (level == ONE || level == '0) state <= ST_OFF;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_OFF;
                        step_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
